demorgan_sweep_ctrl: RTL and testbench
======================================

# demorgan_sweep_ctrl

Sequencer for the De Morgan gate-check datapath. On a push-button start it drives all four `{a,b}` input vectors into the datapath in turn, holding each one for a programmable dwell time. At the end of each dwell it samples the datapath's four gate outputs, checks them against each other and against golden values, and accumulates a pass/fail verdict. It sits between the board button/LEDs and the combinational datapath; during a sweep it mirrors live results on the LEDs, and afterwards it shows the verdict.

## Interface
- `DWELL_CYCLES`, default 50_000_000: cycles each vector is held; legal minimum 2.
- `CNT_W`, default `$clog2(DWELL_CYCLES)`: width of the dwell counter.
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst_n`, in, 1: reset is asynchronous and active-low.
- `start`, in, 1: raw button; asynchronous to `clk`.
- `y_nor`, `y_andn`, `y_nand`, `y_orn`, in, 1 each: datapath outputs !(a|b), !a&!b, !(a&b), !a|!b.
- `a`, `b`, out, 1 each: registered datapath inputs.
- `busy`, out, 1: sweep in progress.
- `done`, out, 1: one-cycle pulse when a sweep completes.
- `pass`, out, 1: verdict of the last sweep, held until the next sweep starts.
- `err_cnt`, out, 3: number of failing vectors in the sweep, 0..4.
- `first_fail`, out, 2: index of the first failing vector; 0 if none.
- `vec_idx`, out, 2: vector currently applied.
- `redled`, `greenled`, `blueled`, out, 1 each: board LEDs.

## Operation
- **Reset values:** all outputs 0; FSM in IDLE; dwell counter 0.
- **Start input:** `start` passes through a 2-flop synchronizer and then a rising-edge detector. Only edges act; holding the button does nothing further.
- **FSM states:** IDLE, DRIVE, CHECK, DONE.
- **IDLE:** on a start edge, go to DRIVE with `vec_idx`=0, {a,b}=00. Clear `err_cnt`, `first_fail` and `pass`. Assert `busy`.
- **DRIVE:** `{a,b}` = `vec_idx` (order 00, 01, 10, 11). The counter counts 0..`DWELL_CYCLES`-1. On the terminal count, go to CHECK.
- **CHECK (1 cycle):** the vector fails if any of the following is false:
  - `y_nor`==`y_andn`
  - `y_nand`==`y_orn`
  - `y_nor`==!(a|b)
  - `y_nand`==!(a&b)
- **On a failing vector:** increment `err_cnt`. If it was 0, load `first_fail` with `vec_idx`.
- **Leaving CHECK:** if `vec_idx`==3, go to DONE. Otherwise increment `vec_idx`, reset the counter, and go to DRIVE.
- **Entering DONE:**
  - `done` pulses for 1 cycle.
  - `busy` drops.
  - `pass` = (`err_cnt`==0), including the last vector's result.
  - `a`/`b` return to 0.
- **In DONE:** a start edge restarts the sweep exactly as from IDLE. There is no path back to IDLE except reset.
- **Start edges during DRIVE/CHECK** are ignored.
- **LEDs:**
  - IDLE: all off.
  - DRIVE/CHECK: red=`y_nor`, green=`y_nand`, blue=per-vector check result (combinational).
  - DONE: blue=`pass`, red=!`pass`, green=0.
- **`err_cnt`** saturates naturally; the maximum is 4, so no wrap is possible.
- **Reset mid-sweep:** asynchronous return to the reset values. No `done` pulse is generated.

## Timing
- Start pin rising to `busy`=1: 3 clk edges (two sync flops plus edge register), with `a`,`b`=00 on that same edge.
- Each vector occupies `DWELL_CYCLES`+1 cycles (DRIVE plus CHECK).
- `busy` stays high for exactly 4×(`DWELL_CYCLES`+1) cycles. `done` is asserted on the cycle after the last CHECK.
- The datapath is combinational. It is sampled `DWELL_CYCLES` cycles after `a`/`b` change, so there is no settling hazard.
- `a`, `b`, `busy`, `done`, `pass`, `err_cnt`, `first_fail` and `vec_idx` are registered. LEDs in DRIVE/CHECK are combinational from the datapath inputs.

## Structure
- **Package `demorgan_pkg`:**
  - FSM state enum.
  - `NUM_VEC`=4.
  - Golden functions `gold_nor(a,b)` and `gold_nand(a,b)`.
- **Sub-module `demorgan_check`:** combinational. Takes a, b and the four y inputs and outputs `vec_ok`. It is instantiated once and drives both the CHECK decision and the live blue LED.
- **Synchronizer:** inline, not a separate module.

## Test plan
All scenarios use `DWELL_CYCLES`=4.
- **Reset and idle:** reset, then hold 20 idle cycles → all outputs 0, `busy`=0, no `done`.
- **Good datapath:** connect a correct model and pulse `start` → `busy` for 20 cycles; {a,b} steps 00, 01, 10, 11 every 5 cycles; `done` pulses once; `pass`=1, `err_cnt`=0, blue=1, red=0.
- **Stuck fault:** force `y_nand` stuck-at-1 → vector 11 fails; `err_cnt`=1, `first_fail`=3, `pass`=0, red=1.
- **Violated law:** force `y_andn`=0 always → vector 00 fails; `err_cnt`=1, `first_fail`=0; then restart from DONE with a correct model → `pass`=1, `err_cnt`=0.
- **Start hold and mid-sweep press:** hold `start` high for 40 cycles → exactly one sweep; a second edge during the sweep → ignored; sweep length still 20 cycles.
- **Reset mid-sweep:** assert `rst_n` low during vector 2 → outputs 0 immediately; no `done` pulse; after release, a fresh `start` runs a full sweep from vector 0.

Source files
------------

// File: rtl/demorgan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demorgan_pkg
// Brief    : Shared state encoding, vector count and golden gate functions.
// Revision : 1.0 - initial release
// ============================================================================
package demorgan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int NUM_VEC = 4;

  function automatic logic gold_nor(input logic a, input logic b);
    return ~(a | b);
  endfunction

  function automatic logic gold_nand(input logic a, input logic b);
    return ~(a & b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/demorgan_check.sv
`default_nettype none
// ============================================================================
// Module   : demorgan_check
// Brief    : Combinational cross-check of the four gate outputs for one vector.
// Revision : 1.0 - initial release
// ============================================================================
module demorgan_check
  import demorgan_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_y_nor,
  input  logic i_y_andn,
  input  logic i_y_nand,
  input  logic i_y_orn,
  output logic o_vec_ok
);

  // Both De Morgan identities must hold and each pair must match the golden gate.
  assign o_vec_ok = (i_y_nor  == i_y_andn) &&
                    (i_y_nand == i_y_orn)  &&
                    (i_y_nor  == gold_nor(i_a, i_b)) &&
                    (i_y_nand == gold_nand(i_a, i_b));

endmodule
`default_nettype wire

// File: rtl/demorgan_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : demorgan_sweep_ctrl
// Brief    : Button-started sweep of all four {a,b} vectors with dwell,
//            per-vector checking, verdict accumulation and LED reporting.
// Revision : 1.0 - initial release
// ============================================================================
module demorgan_sweep_ctrl
  import demorgan_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned CNT_W        = $clog2(DWELL_CYCLES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_nor,
  input  logic       y_andn,
  input  logic       y_nand,
  input  logic       y_orn,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] first_fail,
  output logic [1:0] vec_idx,
  output logic       redled,
  output logic       greenled,
  output logic       blueled
);

  localparam logic [CNT_W-1:0] c_TERM     = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [1:0]       c_LAST_VEC = 2'(NUM_VEC - 1);

  logic r_sync1, r_sync2, r_sync3;
  logic w_start_edge;

  state_t           r_state, w_nxt_state;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic [1:0]       r_vec_idx, w_nxt_idx;
  logic [1:0]       r_first_fail, w_nxt_ff;
  logic [2:0]       r_err_cnt, w_nxt_err;
  logic             r_a, r_b, w_nxt_a, w_nxt_b;
  logic             r_busy, w_nxt_busy;
  logic             r_done, w_nxt_done;
  logic             r_pass, w_nxt_pass;
  logic             w_vec_ok;

  // Two metastability flops, then a third register purely for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= start;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_start_edge = r_sync2 & ~r_sync3;

  demorgan_check u_check (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_y_nor  (y_nor),
    .i_y_andn (y_andn),
    .i_y_nand (y_nand),
    .i_y_orn  (y_orn),
    .o_vec_ok (w_vec_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_vec_idx    <= 2'd0;
      r_first_fail <= 2'd0;
      r_err_cnt    <= 3'd0;
      r_a          <= 1'b0;
      r_b          <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_cnt        <= w_nxt_cnt;
      r_vec_idx    <= w_nxt_idx;
      r_first_fail <= w_nxt_ff;
      r_err_cnt    <= w_nxt_err;
      r_a          <= w_nxt_a;
      r_b          <= w_nxt_b;
      r_busy       <= w_nxt_busy;
      r_done       <= w_nxt_done;
      r_pass       <= w_nxt_pass;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_idx   = r_vec_idx;
    w_nxt_ff    = r_first_fail;
    w_nxt_err   = r_err_cnt;
    w_nxt_a     = r_a;
    w_nxt_b     = r_b;
    w_nxt_busy  = r_busy;
    w_nxt_done  = 1'b0;
    w_nxt_pass  = r_pass;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start_edge) begin
          w_nxt_state = ST_DRIVE;
          w_nxt_cnt   = '0;
          w_nxt_idx   = 2'd0;
          w_nxt_ff    = 2'd0;
          w_nxt_err   = 3'd0;
          w_nxt_a     = 1'b0;
          w_nxt_b     = 1'b0;
          w_nxt_busy  = 1'b1;
          w_nxt_pass  = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (r_cnt == c_TERM) w_nxt_state = ST_CHECK;
        else                 w_nxt_cnt   = r_cnt + CNT_W'(1);
      end
      ST_CHECK: begin
        if (!w_vec_ok) begin
          w_nxt_err = r_err_cnt + 3'd1;
          if (r_err_cnt == 3'd0) w_nxt_ff = r_vec_idx;
        end
        if (r_vec_idx == c_LAST_VEC) begin
          // Verdict uses the updated count so the final vector is included.
          w_nxt_state = ST_DONE;
          w_nxt_busy  = 1'b0;
          w_nxt_done  = 1'b1;
          w_nxt_pass  = (w_nxt_err == 3'd0);
          w_nxt_a     = 1'b0;
          w_nxt_b     = 1'b0;
        end else begin
          w_nxt_state          = ST_DRIVE;
          w_nxt_idx            = r_vec_idx + 2'd1;
          {w_nxt_a, w_nxt_b}   = r_vec_idx + 2'd1;
          w_nxt_cnt            = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    redled   = 1'b0;
    greenled = 1'b0;
    blueled  = 1'b0;
    case (r_state)
      ST_DRIVE, ST_CHECK: begin
        redled   = y_nor;
        greenled = y_nand;
        blueled  = w_vec_ok;
      end
      ST_DONE: begin
        redled  = ~r_pass;
        blueled = r_pass;
      end
      default: ;
    endcase
  end

  assign a          = r_a;
  assign b          = r_b;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_cnt    = r_err_cnt;
  assign first_fail = r_first_fail;
  assign vec_idx    = r_vec_idx;

endmodule
`default_nettype wire

// File: tb/tb_demorgan_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_demorgan_sweep_ctrl
// Brief    : Directed, table-driven bench for demorgan_sweep_ctrl (dwell 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_demorgan_sweep_ctrl;

  localparam int unsigned DWELL = 4;
  localparam int SWEEP_LEN      = 4 * (DWELL + 1);
  localparam int WINDOW         = 80;
  localparam int NO_PRESS       = 1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       y_nor, y_andn, y_nand, y_orn;
  logic       a, b, busy, done, pass;
  logic [2:0] err_cnt;
  logic [1:0] first_fail, vec_idx;
  logic       redled, greenled, blueled;
  int         mode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Datapath model; mode selects an injected fault (0 = correct).
  assign y_nor  = (mode == 4) ? (a | b) : ~(a | b);
  assign y_andn = (mode == 2) ? 1'b0 : (mode == 4) ? (a | b) : (~a & ~b);
  assign y_nand = (mode == 1) ? 1'b1 : ~(a & b);
  assign y_orn  = (mode == 3) ? 1'b0 : (~a | ~b);

  demorgan_sweep_ctrl #(.DWELL_CYCLES(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .y_nor(y_nor), .y_andn(y_andn), .y_nand(y_nand), .y_orn(y_orn),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_fail(first_fail), .vec_idx(vec_idx),
    .redled(redled), .greenled(greenled), .blueled(blueled)
  );

  function automatic logic exp_ok(input int m, input logic va, input logic vb);
    case (m)
      1:       return ~(va & vb);
      2:       return va | vb;
      3:       return va & vb;
      4:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         mode;
    int         hold;
    int         press2;
    logic [2:0] err;
    logic [1:0] ff;
    logic       pass;
  } vec_t;

  vec_t tbl[7];

  // Press start, observe a fixed window, then check the whole sweep and verdict.
  task automatic run_sweep(input vec_t v);
    int lat = -1, busy_len = 0, done_cnt = 0, done_at = -1, rises = 0, seq_err = 0;
    logic prev_busy = 1'b0;
    logic [1:0] idx;
    mode  = v.mode;
    start = 1'b1;
    for (int cyc = 1; cyc <= WINDOW; cyc++) begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        rises++;
        if (lat < 0) lat = cyc;
      end
      if (busy) begin
        idx = 2'(busy_len / (DWELL + 1));
        if (a !== idx[1] || b !== idx[0] || vec_idx !== idx) seq_err++;
        if (redled !== y_nor || greenled !== y_nand || blueled !== exp_ok(v.mode, a, b)) seq_err++;
        if (done) seq_err++;
        busy_len++;
      end
      if (done) begin
        done_cnt++;
        done_at = cyc;
      end
      prev_busy = busy;
      start = (cyc < v.hold) || (cyc >= v.press2 && cyc < v.press2 + 3);
    end
    start = 1'b0;
    chk("start_latency", lat, 3);
    chk("busy_rises", rises, 1);
    chk("busy_len", busy_len, SWEEP_LEN);
    chk("done_count", done_cnt, 1);
    chk("done_cycle", done_at, lat + SWEEP_LEN);
    chk("sweep_sequence", seq_err, 0);
    chk("err_cnt", err_cnt, v.err);
    chk("first_fail", first_fail, v.ff);
    chk("pass", pass, v.pass);
    chk("leds_done", {redled, greenled, blueled}, {~v.pass, 1'b0, v.pass});
    chk("ab_after_done", {busy, a, b}, 0);
  endtask

  initial begin
    int bad;
    int waited;
    //               mode hold press2    err   ff    pass
    tbl[0] = '{0,  1, NO_PRESS, 3'd0, 2'd0, 1'b1};
    tbl[1] = '{1,  1, NO_PRESS, 3'd1, 2'd3, 1'b0};
    tbl[2] = '{2,  1, NO_PRESS, 3'd1, 2'd0, 1'b0};
    tbl[3] = '{0,  1, NO_PRESS, 3'd0, 2'd0, 1'b1};
    tbl[4] = '{0, 40, NO_PRESS, 3'd0, 2'd0, 1'b1};
    tbl[5] = '{3,  1, 12,       3'd3, 2'd0, 1'b0};
    tbl[6] = '{4,  1, NO_PRESS, 3'd4, 2'd0, 1'b0};

    mode  = 0;
    start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {a, b, busy, done, pass, err_cnt, first_fail, vec_idx, redled, greenled, blueled}, 0);
    rst_n = 1'b1;

    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({a, b, busy, done, pass, err_cnt, first_fail, vec_idx, redled, greenled, blueled} != 0)
        bad++;
    end
    chk("idle_quiet", bad, 0);

    for (int i = 0; i < 7; i++) run_sweep(tbl[i]);

    // Reset asserted while vector 2 is applied.
    mode  = 0;
    start = 1'b1;
    waited = 0;
    while (vec_idx != 2'd2 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    start = 1'b0;
    chk("reach_vec2", (waited < 60) ? 1 : 0, 1);
    chk("busy_at_vec2", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {a, b, busy, done, pass, err_cnt, first_fail, vec_idx, redled, greenled, blueled}, 0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    chk("no_done_after_reset", bad, 0);
    run_sweep(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
